alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin scheduler that shares one combinational 8-bit ALU (zx/nx/zy/ny/f/no control style) between four requesters. Each requester presents a 5-bit function opcode and two 8-bit operands. The arbiter grants one requester at a time, decodes the opcode into the six ALU control bits and drives the shared ALU. It then registers the result (o, zr, ng) onto a common result bus tagged with the requester id. It sits between the ALU instance and the client blocks that previously owned private ALU copies.

## Interface
- NREQ, 4, number of requesters (fixed at 4; id width 2)
- W, 8, operand/result width
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  4  per-requester request level; held until matching done
- op  in  20  packed opcodes, requester i at op[5i+4:5i]
- x  in  32  packed X operands, requester i at x[8i+7:8i]
- y  in  32  packed Y operands, requester i at y[8i+7:8i]
- done  out  4  one-cycle completion pulse per requester
- res_valid  out  1  one-cycle result strobe (same cycle as done)
- res_id  out  2  requester the result belongs to
- res_o  out  8  registered ALU result
- res_zr  out  1  registered zero flag
- res_ng  out  1  registered negative flag
- res_err  out  1  opcode was illegal (>17)
- busy  out  1  high in EXEC and DONE states
- op_cnt  out  8  completed-operation counter, wraps 255->0
- alu_x, alu_y  out  8 each  operands to shared ALU
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU controls
- alu_o  in  8; alu_zr, alu_ng  in  1 each  combinational ALU outputs

## Operation
- FSM states: IDLE -> EXEC -> DONE -> IDLE. There are no other transitions, except that rst forces IDLE from any state.
- IDLE: if req != 0, grant the first set bit searching from rr_ptr upward, wrapping modulo 4. On the grant edge, latch id, op, x and y into internal registers. Set rr_ptr = id+1 mod 4. Go to EXEC.
- IDLE with req == 0: stay; no register changes.
- EXEC: latched operands and decoded controls drive alu_*. At the end of EXEC, capture alu_o/zr/ng into res_*, set res_id, and go to DONE.
- DONE: res_valid=1, done[res_id]=1, op_cnt+1. req is ignored in this state, so the requester drops req here. Go to IDLE.
- Opcode decode (zx,nx,zy,ny,f,no):
  - 0: 0 = 101000
  - 1: 1 = 111111
  - 2: -1 = 111010
  - 3: x = 001010
  - 4: y = 100010
  - 5: !x = 011010
  - 6: !y = 100110
  - 7: -x = 001111
  - 8: -y = 110011
  - 9: x+1 = 011111
  - 10: y+1 = 110111
  - 11: x-1 = 001110
  - 12: y-1 = 110010
  - 13: x+y = 000010
  - 14: x-y = 010011
  - 15: y-x = 000111
  - 16: x&y = 000000
  - 17: x|y = 010101
- Illegal opcode 18..31: controls drive 000000. In the capture, res_o=0, res_zr=0, res_ng=0 and res_err=1. The op still completes normally, with done pulsed and op_cnt incremented. res_err=0 for legal opcodes.
- Arithmetic is modulo 2^8 (wrap, no carry out). zr is set when o==0; ng is o[7].
- alu_x, alu_y and the controls hold their last values outside EXEC.
- res_* hold their values until the next capture. res_valid and done are pulses.
- A requester dropping req before its grant is simply not granted. A requester dropping req after its grant does not cancel the op.

## Timing
- Reset values:
  - state IDLE, rr_ptr=0
  - done=0, res_valid=0, res_id=0, res_o=0, res_zr=0, res_ng=0, res_err=0
  - busy=0, op_cnt=0
  - alu_x=0, alu_y=0, all alu controls 0
- Latency: req sampled high at edge k (IDLE) produces EXEC during k..k+1 and a capture at edge k+1. done and res_valid are high for the cycle after edge k+1 and fall at edge k+2.
- Throughput: one op per 3 cycles. A continuously requesting set of N requesters is each served once every 3N cycles.
- Simultaneous requests: strict rotation from rr_ptr; no requester waits more than 3 grants.
- Reset asserted mid-op (EXEC or DONE): immediate return to reset values. No done is issued for the aborted op and op_cnt is not incremented.

## Test plan
- Single op: after reset, req=0001, op0=13, x0=8'h76, y0=8'h2A. Required: done[0] pulses 2 cycles after the grant edge; res_o=8'hA0, res_ng=1, res_zr=0, res_id=0, op_cnt=1.
- Wrap/zero: op=9, x=8'hFF. Required: res_o=8'h00, res_zr=1, res_ng=0. Then op=0 gives res_o=0, res_zr=1. Then op=2 gives res_o=8'hFF, res_ng=1.
- Round robin: all four req held high from reset, with op=14, x=8'h76, y=8'h2A for each. Required: grants in order 0,1,2,3,0…; done pulses 3 cycles apart; each res_o=8'h4C.
- Pointer fairness: after requester 2 is served, req=0101 is served as 0 first, then 2.
- Illegal opcode: op=20. Required: res_err=1, res_o=0, res_zr=0, res_ng=0, done pulses, op_cnt increments. The next legal op clears res_err.
- Reset mid-op: assert rst during EXEC. Required: all outputs return to reset values asynchronously, no done pulse, op_cnt=0. After release, a held req is re-granted starting from requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin scheduler sharing one combinational zx/nx/zy/ny/f/no ALU between
// four requesters. Results are registered onto a common result bus tagged with the requester id.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] op,
  input  logic [W*NREQ-1:0] x,
  input  logic [W*NREQ-1:0] y,
  output logic [NREQ-1:0]   done,
  output logic              res_valid,
  output logic [1:0]        res_id,
  output logic [W-1:0]      res_o,
  output logic              res_zr,
  output logic              res_ng,
  output logic              res_err,
  output logic              busy,
  output logic [7:0]        op_cnt,
  output logic [W-1:0]      alu_x,
  output logic [W-1:0]      alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [W-1:0]      alu_o,
  input  logic              alu_zr,
  input  logic              alu_ng
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_id;
  logic [W-1:0] r_x;
  logic [W-1:0] r_y;
  logic [5:0]  r_ctrl;
  logic        r_illegal;
  logic [1:0]  r_res_id;
  logic [W-1:0] r_res_o;
  logic        r_res_zr;
  logic        r_res_ng;
  logic        r_res_err;
  logic [7:0]  r_cnt;

  logic        w_gnt_vld;
  logic [1:0]  w_gnt_id;
  logic [1:0]  w_idx;
  logic [4:0]  w_op;

  // Control word order is {zx, nx, zy, ny, f, no}; illegal codes give all zeros.
  function automatic logic [5:0] f_decode(input logic [4:0] opc);
    case (opc)
      5'd0:    return 6'b101000;
      5'd1:    return 6'b111111;
      5'd2:    return 6'b111010;
      5'd3:    return 6'b001010;
      5'd4:    return 6'b100010;
      5'd5:    return 6'b011010;
      5'd6:    return 6'b100110;
      5'd7:    return 6'b001111;
      5'd8:    return 6'b110011;
      5'd9:    return 6'b011111;
      5'd10:   return 6'b110111;
      5'd11:   return 6'b001110;
      5'd12:   return 6'b110010;
      5'd13:   return 6'b000010;
      5'd14:   return 6'b010011;
      5'd15:   return 6'b000111;
      5'd16:   return 6'b000000;
      5'd17:   return 6'b010101;
      default: return 6'b000000;
    endcase
  endfunction

  // Scan offsets high to low so the nearest set bit at or after r_ptr wins.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    w_gnt_vld = 1'b0;
    w_gnt_id  = r_ptr;
    w_idx     = r_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (req[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end

  assign w_op = op[5*w_gnt_id +: 5];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_vld) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (r_state == ST_EXEC) || (r_state == ST_DONE);
    res_valid = (r_state == ST_DONE);
    done      = '0;
    if (r_state == ST_DONE) done[r_res_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
      r_res_id  <= '0;
      r_res_o   <= '0;
      r_res_zr  <= 1'b0;
      r_res_ng  <= 1'b0;
      r_res_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_id      <= w_gnt_id;
            r_ptr     <= w_gnt_id + 2'd1;
            r_x       <= x[W*w_gnt_id +: W];
            r_y       <= y[W*w_gnt_id +: W];
            r_ctrl    <= f_decode(w_op);
            r_illegal <= (w_op > 5'd17);
          end
        end
        ST_EXEC: begin
          r_res_id <= r_id;
          if (r_illegal) begin
            r_res_o   <= '0;
            r_res_zr  <= 1'b0;
            r_res_ng  <= 1'b0;
            r_res_err <= 1'b1;
          end else begin
            r_res_o   <= alu_o;
            r_res_zr  <= alu_zr;
            r_res_ng  <= alu_ng;
            r_res_err <= 1'b0;
          end
        end
        ST_DONE: r_cnt <= r_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Operands and controls come from grant-time registers, so they hold outside EXEC.
  assign alu_x  = r_x;
  assign alu_y  = r_y;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = r_ctrl;

  assign res_id  = r_res_id;
  assign res_o   = r_res_o;
  assign res_zr  = r_res_zr;
  assign res_ng  = r_res_ng;
  assign res_err = r_res_err;
  assign op_cnt  = r_cnt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port.
// Expected values are hand-computed constants.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] op;
  logic [31:0] x;
  logic [31:0] y;
  logic [3:0]  done;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [7:0]  res_o;
  logic        res_zr;
  logic        res_ng;
  logic        res_err;
  logic        busy;
  logic [7:0]  op_cnt;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [7:0]  alu_o;
  logic        alu_zr;
  logic        alu_ng;

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .x         (x),
    .y         (y),
    .done      (done),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_o     (res_o),
    .res_zr    (res_zr),
    .res_ng    (res_ng),
    .res_err   (res_err),
    .busy      (busy),
    .op_cnt    (op_cnt),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_zx    (alu_zx),
    .alu_nx    (alu_nx),
    .alu_zy    (alu_zy),
    .alu_ny    (alu_ny),
    .alu_f     (alu_f),
    .alu_no    (alu_no),
    .alu_o     (alu_o),
    .alu_zr    (alu_zr),
    .alu_ng    (alu_ng)
  );

  // Behavioural zx/nx/zy/ny/f/no ALU standing in for the shared instance.
  always_comb begin
    logic [7:0] xx, yy, oo;
    xx = alu_zx ? 8'h00 : alu_x;
    xx = alu_nx ? ~xx : xx;
    yy = alu_zy ? 8'h00 : alu_y;
    yy = alu_ny ? ~yy : yy;
    oo = alu_f ? (xx + yy) : (xx & yy);
    oo = alu_no ? ~oo : oo;
    alu_o  = oo;
    alu_zr = (oo == 8'h00);
    alu_ng = oo[7];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int id, input logic [4:0] o, input logic [7:0] xv, input logic [7:0] yv);
    op[5*id +: 5] = o;
    x[8*id +: 8]  = xv;
    y[8*id +: 8]  = yv;
  endtask

  // Advance until a done pulse is seen or the budget runs out; n counts edges.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done == 4'b0000 && n < 30);
    check(tag, 32'(done != 4'b0000), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    op  = '0;
    x   = '0;
    y   = '0;
    tick();
    tick();

    // Reset state
    check("rst_done",  32'(done), 32'h0);
    check("rst_valid", 32'(res_valid), 32'h0);
    check("rst_res",   32'({res_id, res_o, res_zr, res_ng, res_err}), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_cnt",   32'(op_cnt), 32'h0);
    check("rst_alu",   32'({alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'h0);
    rst = 1'b0;
    tick();

    // Single op: x+y = 0x76 + 0x2A
    load(0, 5'd13, 8'h76, 8'h2A);
    req = 4'b0001;
    tick();
    check("single_exec_busy", 32'(busy), 32'h1);
    check("single_exec_alu",  32'({alu_x, alu_y}), 32'h762A);
    check("single_exec_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'b000010);
    check("single_exec_nodone", 32'(done), 32'h0);
    tick();
    check("single_done",  32'(done), 32'b0001);
    check("single_valid", 32'(res_valid), 32'h1);
    check("single_res",   32'({res_id, res_o, res_zr, res_ng, res_err}), 32'({2'd0, 8'hA0, 1'b0, 1'b1, 1'b0}));
    req = 4'b0000;
    tick();
    check("single_done_fall", 32'({done, res_valid}), 32'h0);
    check("single_cnt", 32'(op_cnt), 32'd1);
    tick();
    tick();
    check("idle_hold", 32'({busy, res_o, op_cnt}), 32'({1'b0, 8'hA0, 8'd1}));

    // Wrap to zero: x+1 with x=0xFF
    load(0, 5'd9, 8'hFF, 8'h00);
    req = 4'b0001;
    wait_done("wrap_to", n_cyc);
    check("wrap_lat", 32'(n_cyc), 32'd2);
    check("wrap_res", 32'({res_o, res_zr, res_ng}), 32'({8'h00, 1'b1, 1'b0}));
    req = 4'b0000;
    tick();
    load(0, 5'd0, 8'h5A, 8'hA5);
    req = 4'b0001;
    wait_done("zero_to", n_cyc);
    check("zero_res", 32'({res_o, res_zr, res_ng}), 32'({8'h00, 1'b1, 1'b0}));
    req = 4'b0000;
    tick();
    load(0, 5'd2, 8'h12, 8'h34);
    req = 4'b0001;
    wait_done("minus1_to", n_cyc);
    check("minus1_res", 32'({res_o, res_zr, res_ng}), 32'({8'hFF, 1'b0, 1'b1}));
    req = 4'b0000;
    tick();
    check("cnt_after4", 32'(op_cnt), 32'd4);

    // Pointer fairness: serve 2 alone, then 0 and 2 together go 0 first
    load(2, 5'd3, 8'h55, 8'h00);
    req = 4'b0100;
    wait_done("serve2_to", n_cyc);
    check("serve2", 32'({done, res_id, res_o}), 32'({4'b0100, 2'd2, 8'h55}));
    req = 4'b0000;
    tick();
    load(0, 5'd13, 8'h01, 8'h02);
    load(2, 5'd16, 8'hF0, 8'h3C);
    req = 4'b0101;
    wait_done("fair0_to", n_cyc);
    check("fair_first", 32'({done, res_id, res_o}), 32'({4'b0001, 2'd0, 8'h03}));
    req = 4'b0100;
    wait_done("fair2_to", n_cyc);
    check("fair_second", 32'({done, res_id, res_o}), 32'({4'b0100, 2'd2, 8'h30}));
    check("fair_gap", 32'(n_cyc), 32'd3);
    req = 4'b0000;
    tick();
    check("cnt_after7", 32'(op_cnt), 32'd7);

    // Illegal opcodes 20 and 18, legal 17 and 4 clear the error
    load(1, 5'd20, 8'h12, 8'h34);
    req = 4'b0010;
    wait_done("ill20_to", n_cyc);
    check("ill20_res", 32'({done, res_id, res_o, res_zr, res_ng, res_err}),
          32'({4'b0010, 2'd1, 8'h00, 1'b0, 1'b0, 1'b1}));
    req = 4'b0000;
    tick();
    check("ill20_cnt", 32'(op_cnt), 32'd8);
    load(3, 5'd17, 8'h0F, 8'h30);
    req = 4'b1000;
    wait_done("or17_to", n_cyc);
    check("or17_res", 32'({res_id, res_o, res_zr, res_ng, res_err}), 32'({2'd3, 8'h3F, 1'b0, 1'b0, 1'b0}));
    req = 4'b0000;
    tick();
    load(3, 5'd18, 8'hFF, 8'hFF);
    req = 4'b1000;
    wait_done("ill18_to", n_cyc);
    check("ill18_res", 32'({res_o, res_zr, res_ng, res_err}), 32'({8'h00, 1'b0, 1'b0, 1'b1}));
    req = 4'b0000;
    tick();
    load(1, 5'd4, 8'h11, 8'h80);
    req = 4'b0010;
    wait_done("y4_to", n_cyc);
    check("y4_res", 32'({res_o, res_zr, res_ng, res_err}), 32'({8'h80, 1'b0, 1'b1, 1'b0}));
    req = 4'b0000;
    tick();
    check("cnt_after11", 32'(op_cnt), 32'd11);

    // Round robin: all four held from reset, x-y = 0x4C
    rst = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 5'd14, 8'h76, 8'h2A);
    req = 4'b1111;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_done("rr_to", n_cyc);
      check("rr_done", 32'(done), 32'(4'b0001 << (k % 4)));
      check("rr_res",  32'({res_id, res_o}), 32'({2'(k % 4), 8'h4C}));
      check("rr_gap",  32'(n_cyc), (k == 0) ? 32'd2 : 32'd3);
    end
    tick();
    check("rr_cnt", 32'(op_cnt), 32'd5);

    // Reset mid-op: wait for EXEC, then assert rst between edges
    n_cyc = 0;
    while (!(busy && !res_valid) && n_cyc < 10) begin
      tick();
      n_cyc++;
    end
    check("midrst_exec", 32'({busy, res_valid}), 32'b10);
    rst = 1'b1;
    #1;
    check("midrst_out", 32'({done, res_valid, busy, res_id, res_o, res_zr, res_ng, res_err}), 32'h0);
    check("midrst_cnt", 32'(op_cnt), 32'h0);
    check("midrst_alu", 32'({alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'h0);
    tick();
    check("midrst_hold", 32'({done, busy, op_cnt}), 32'h0);
    rst = 1'b0;
    wait_done("regrant_to", n_cyc);
    check("regrant", 32'({done, res_id, res_o}), 32'({4'b0001, 2'd0, 8'h4C}));
    req = 4'b0000;
    tick();
    check("regrant_cnt", 32'(op_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
